// File: rtl/motor_pkg.sv
// Shared definitions for the motor direction sequencer: bridge control codes,
// FSM state encoding, setpoint field positions and the decoded request type.
package motor_pkg;

    // H-bridge control codes
    localparam logic [1:0] CTRL_COAST = 2'b00;
    localparam logic [1:0] CTRL_FWD   = 2'b01;
    localparam logic [1:0] CTRL_REV   = 2'b10;
    localparam logic [1:0] CTRL_BRAKE = 2'b11;

    // Sequencer state encoding
    localparam logic [2:0] ST_STOP    = 3'd0;
    localparam logic [2:0] ST_RUN_FWD = 3'd1;
    localparam logic [2:0] ST_RUN_REV = 3'd2;
    localparam logic [2:0] ST_BRAKE   = 3'd3;
    localparam logic [2:0] ST_DEAD    = 3'd4;

    // Field positions for the reference 17-bit setpoint. A wider or narrower
    // setpoint keeps the 8-bit fraction and moves sign/magnitude MSB with it.
    localparam int SETPOINT_WIDTH = 17;
    localparam int SIGN_BIT       = 16;
    localparam int MAG_MSB        = 15;
    localparam int MAG_LSB        = 8;

    typedef enum logic [1:0] {
        REQ_STOP = 2'd0,
        REQ_FWD  = 2'd1,
        REQ_REV  = 2'd2
    } req_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter used to time the BRAKE and DEAD dwell periods.
// Load wins over enable; the count parks at zero and zero is flagged combinationally.
module seq_timer #(
    parameter int CNT_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 enable,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of always-block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motor_dir_sequencer.sv
// Safe-reversal sequencer between the velocity setpoint path and the H-bridge:
// any polarity change goes through BRAKE then DEAD (coast) before driving again.
module motor_dir_sequencer
    import motor_pkg::*;
#(
    parameter int N_DATAWIDTH     = 17,
    parameter int BRAKE_CYCLES    = 50000,
    parameter int DEADTIME_CYCLES = 500,
    parameter int CNT_WIDTH       = 17
) (
    input  logic                   MOTOR_DIR_SEQ_CLOCK_50,
    input  logic                   MOTOR_DIR_SEQ_RESET_InLow,
    input  logic [N_DATAWIDTH-1:0] MOTOR_DIR_SEQ_W_InBus,
    input  logic                   MOTOR_DIR_SEQ_W_LOAD_In,
    output logic [1:0]             MOTOR_DIR_SEQ_CONTROL_OutBus,
    output logic                   MOTOR_DIR_SEQ_PWM_EN_Out,
    output logic [N_DATAWIDTH-1:0] MOTOR_DIR_SEQ_W_OutBus,
    output logic                   MOTOR_DIR_SEQ_BUSY_Out
);

    localparam int WIDTH_SHIFT = N_DATAWIDTH - SETPOINT_WIDTH;
    localparam int SIGN_POS    = SIGN_BIT + WIDTH_SHIFT;
    localparam int MAG_POS_MSB = MAG_MSB + WIDTH_SHIFT;

    localparam logic [CNT_WIDTH-1:0] BRAKE_LOAD = CNT_WIDTH'(BRAKE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DEAD_LOAD  = CNT_WIDTH'(DEADTIME_CYCLES - 1);

    logic                   clk;
    logic                   rst_n;
    logic [N_DATAWIDTH-1:0] setpoint;
    logic [2:0]             state;
    logic [2:0]             state_next;
    req_t                   req;
    logic                   timer_load;
    logic [CNT_WIDTH-1:0]   timer_value;
    logic                   timer_enable;
    logic                   timer_zero;

    assign clk   = MOTOR_DIR_SEQ_CLOCK_50;
    assign rst_n = MOTOR_DIR_SEQ_RESET_InLow;

    // Loads are accepted in every state; BRAKE/DEAD only consult the value at their exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setpoint <= '0;
        end else if (MOTOR_DIR_SEQ_W_LOAD_In) begin
            setpoint <= MOTOR_DIR_SEQ_W_InBus;
        end
    end

    // A zero integer magnitude means stop, whatever the sign and fraction bits say.
    always_comb begin
        req = REQ_STOP;
        if (setpoint[MAG_POS_MSB:MAG_LSB] != '0) begin
            req = setpoint[SIGN_POS] ? REQ_REV : REQ_FWD;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_STOP: begin
                if (req == REQ_FWD) begin
                    state_next = ST_RUN_FWD;
                end else if (req == REQ_REV) begin
                    state_next = ST_RUN_REV;
                end
            end
            ST_RUN_FWD: begin
                if (req == REQ_STOP) begin
                    state_next = ST_STOP;
                end else if (req == REQ_REV) begin
                    state_next  = ST_BRAKE;
                    timer_load  = 1'b1;
                    timer_value = BRAKE_LOAD;
                end
            end
            ST_RUN_REV: begin
                if (req == REQ_STOP) begin
                    state_next = ST_STOP;
                end else if (req == REQ_FWD) begin
                    state_next  = ST_BRAKE;
                    timer_load  = 1'b1;
                    timer_value = BRAKE_LOAD;
                end
            end
            ST_BRAKE: begin
                if (timer_zero) begin
                    state_next  = ST_DEAD;
                    timer_load  = 1'b1;
                    timer_value = DEAD_LOAD;
                end
            end
            ST_DEAD: begin
                if (timer_zero) begin
                    case (req)
                        REQ_FWD: state_next = ST_RUN_FWD;
                        REQ_REV: state_next = ST_RUN_REV;
                        default: state_next = ST_STOP;
                    endcase
                end
            end
            default: state_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    assign timer_enable = (state == ST_BRAKE) || (state == ST_DEAD);

    seq_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_enable),
        .zero       (timer_zero)
    );

    // Moore outputs: the bridge code depends on state alone, so it can never
    // step directly between drive polarities.
    always_comb begin
        case (state)
            ST_RUN_FWD: MOTOR_DIR_SEQ_CONTROL_OutBus = CTRL_FWD;
            ST_RUN_REV: MOTOR_DIR_SEQ_CONTROL_OutBus = CTRL_REV;
            ST_DEAD:    MOTOR_DIR_SEQ_CONTROL_OutBus = CTRL_COAST;
            default:    MOTOR_DIR_SEQ_CONTROL_OutBus = CTRL_BRAKE;
        endcase
    end

    assign MOTOR_DIR_SEQ_PWM_EN_Out = (state == ST_RUN_FWD) || (state == ST_RUN_REV);
    assign MOTOR_DIR_SEQ_BUSY_Out   = timer_enable;
    assign MOTOR_DIR_SEQ_W_OutBus   = MOTOR_DIR_SEQ_PWM_EN_Out ? setpoint : '0;

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Directed bench for motor_dir_sequencer with short dwell times (brake 4, dead 2)
// followed by random loads checked against the bridge safety invariants.
module tb_motor_dir_sequencer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    logic [16:0] w_in  = '0;
    logic [1:0]  control;
    logic        pwm_en;
    logic [16:0] w_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    motor_dir_sequencer #(
        .N_DATAWIDTH    (17),
        .BRAKE_CYCLES   (4),
        .DEADTIME_CYCLES(2),
        .CNT_WIDTH      (17)
    ) dut (
        .MOTOR_DIR_SEQ_CLOCK_50      (clk),
        .MOTOR_DIR_SEQ_RESET_InLow   (rst_n),
        .MOTOR_DIR_SEQ_W_InBus       (w_in),
        .MOTOR_DIR_SEQ_W_LOAD_In     (load),
        .MOTOR_DIR_SEQ_CONTROL_OutBus(control),
        .MOTOR_DIR_SEQ_PWM_EN_Out    (pwm_en),
        .MOTOR_DIR_SEQ_W_OutBus      (w_out),
        .MOTOR_DIR_SEQ_BUSY_Out      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ctrl, input logic pwm,
                              input logic bsy, input logic [16:0] wout);
        check({tag, ".control"}, 32'(control), 32'(ctrl));
        check({tag, ".pwm_en"},  32'(pwm_en),  32'(pwm));
        check({tag, ".busy"},    32'(busy),    32'(bsy));
        check({tag, ".w_out"},   32'(w_out),   32'(wout));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [16:0] value);
        load = 1'b1;
        w_in = value;
        tick();
        load = 1'b0;
    endtask

    logic [16:0] rand_table [6] = '{17'h00A00, 17'h10500, 17'h100FF, 17'h00000, 17'h00300, 17'h1FF00};
    logic [1:0]  prev_ctrl;

    initial begin
        // Reset held, then released between edges
        #1 rst_n = 1'b0;
        #10;
        expect_out("rst_hold", 2'b11, 1'b0, 1'b0, 17'h0);
        #2 rst_n = 1'b1;
        tick();
        expect_out("rst_rel", 2'b11, 1'b0, 1'b0, 17'h0);

        // Start from stop: +10 rad/s, drive one edge after the load edge
        load_w(17'h00A00);
        expect_out("start_e1", 2'b11, 1'b0, 1'b0, 17'h0);
        tick();
        expect_out("start", 2'b01, 1'b1, 1'b0, 17'h00A00);

        // Reversal to -5 rad/s: 01, 11 x4, 00 x2, 10
        load_w(17'h10500);
        expect_out("rev_e1", 2'b01, 1'b1, 1'b0, 17'h10500);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("rev_brake", 2'b11, 1'b0, 1'b1, 17'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("rev_dead", 2'b00, 1'b0, 1'b1, 17'h0);
        end
        tick();
        expect_out("rev_run", 2'b10, 1'b1, 1'b0, 17'h10500);

        // Fraction-only magnitude means stop; no brake/dead on the way
        load_w(17'h100FF);
        expect_out("stop_e1", 2'b10, 1'b1, 1'b0, 17'h100FF);
        tick();
        expect_out("stop", 2'b11, 1'b0, 1'b0, 17'h0);
        tick();
        expect_out("stop_stay", 2'b11, 1'b0, 1'b0, 17'h0);

        // Load back to forward while braking: full sequence still runs
        load_w(17'h00A00);
        tick();
        expect_out("lb_fwd", 2'b01, 1'b1, 1'b0, 17'h00A00);
        load_w(17'h10500);
        tick();
        expect_out("lb_brake1", 2'b11, 1'b0, 1'b1, 17'h0);
        load_w(17'h00300);
        expect_out("lb_brake2", 2'b11, 1'b0, 1'b1, 17'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("lb_brake34", 2'b11, 1'b0, 1'b1, 17'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("lb_dead", 2'b00, 1'b0, 1'b1, 17'h0);
        end
        tick();
        expect_out("lb_end", 2'b01, 1'b1, 1'b0, 17'h00300);

        // Zero load during DEAD: sequence ends in STOP
        load_w(17'h10500);
        tick();
        expect_out("ld_brake1", 2'b11, 1'b0, 1'b1, 17'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("ld_brake", 2'b11, 1'b0, 1'b1, 17'h0);
        end
        tick();
        expect_out("ld_dead1", 2'b00, 1'b0, 1'b1, 17'h0);
        load_w(17'h00000);
        expect_out("ld_dead2", 2'b00, 1'b0, 1'b1, 17'h0);
        tick();
        expect_out("ld_stop", 2'b11, 1'b0, 1'b0, 17'h0);

        // Load on the expiry edge: exit uses the old (reverse) request, then reverses again
        load_w(17'h00A00);
        tick();
        expect_out("ex_fwd", 2'b01, 1'b1, 1'b0, 17'h00A00);
        load_w(17'h10500);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("ex_brake", 2'b11, 1'b0, 1'b1, 17'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("ex_dead", 2'b00, 1'b0, 1'b1, 17'h0);
        end
        load_w(17'h00200);
        expect_out("ex_exit", 2'b10, 1'b1, 1'b0, 17'h00200);
        tick();
        expect_out("ex_rebrake", 2'b11, 1'b0, 1'b1, 17'h0);

        // Asynchronous reset in BRAKE, mid-cycle; setpoint is cleared too
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 2'b11, 1'b0, 1'b0, 17'h0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("rst_after", 2'b11, 1'b0, 1'b0, 17'h0);
        tick();
        expect_out("rst_after2", 2'b11, 1'b0, 1'b0, 17'h0);

        // Random loads against the safety invariants
        prev_ctrl = control;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) begin
                load_w(rand_table[$urandom_range(5)]);
            end else begin
                tick();
            end
            check("inv_no_flip",
                  32'(((prev_ctrl == 2'b01) && (control == 2'b10)) ||
                      ((prev_ctrl == 2'b10) && (control == 2'b01))), 32'd0);
            check("inv_pwm_drive", 32'(pwm_en), 32'((control == 2'b01) || (control == 2'b10)));
            check("inv_pwm_busy", 32'(pwm_en && busy), 32'd0);
            check("inv_wout_gate", 32'(!pwm_en && (w_out != '0)), 32'd0);
            prev_ctrl = control;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
